// File: rtl/store_seq_checker.sv
// store_seq_checker: watches CPU stores for a milestone store followed by a final store,
// reporting pass or a coded failure, with store and cycle counters and a timeout.
module store_seq_checker #(
    parameter logic [31:0] MILESTONE_ADDR = 32'd80,
    parameter logic [31:0] MILESTONE_DATA = 32'd7,
    parameter logic [31:0] FINAL_ADDR     = 32'd84,
    parameter logic [31:0] FINAL_DATA     = 32'd7,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    input  logic [31:0] pc,
    output logic        milestone,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  fail_code,
    output logic [31:0] fail_pc,
    output logic [7:0]  store_count,
    output logic [15:0] cycle_count
);
    typedef enum logic [1:0] {WAIT_MS, WAIT_FINAL, PASS, FAIL} state_t;
    state_t state;
    logic waiting, go_ms, go_pass;
    logic [2:0] code;
    assign waiting = (state == WAIT_MS) || (state == WAIT_FINAL);
    // Store-driven outcomes are resolved first; timeout only applies when no store moved the FSM.
    always_comb begin
        code = 3'd0;
        go_ms = 1'b0;
        go_pass = 1'b0;
        if (memwrite) begin
            if (dataaddr == MILESTONE_ADDR) begin
                if (writedata != MILESTONE_DATA) code = 3'd1;
                else go_ms = (state == WAIT_MS);
            end else if (dataaddr == FINAL_ADDR) begin
                if (state == WAIT_MS) code = 3'd3;
                else if (writedata != FINAL_DATA) code = 3'd4;
                else go_pass = 1'b1;
            end else begin
                code = 3'd2;
            end
        end
        if (code == 3'd0 && !go_ms && !go_pass && cycle_count == TIMEOUT_CYCLES - 16'd1)
            code = 3'd5;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_MS;
            milestone   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 3'd0;
            fail_pc     <= 32'd0;
            store_count <= 8'd0;
            cycle_count <= 16'd0;
        end else if (waiting) begin
            cycle_count <= (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
            if (memwrite && store_count != 8'hFF) store_count <= store_count + 8'd1;
            if (code != 3'd0) begin
                state     <= FAIL;
                fail      <= 1'b1;
                done      <= 1'b1;
                fail_code <= code;
                fail_pc   <= pc;
            end else if (go_pass) begin
                state <= PASS;
                pass  <= 1'b1;
                done  <= 1'b1;
            end else if (go_ms) begin
                state     <= WAIT_FINAL;
                milestone <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_store_seq_checker.sv
// tb_store_seq_checker: directed scenarios plus randomized store streams checked
// against a flag-based reference model of the store sequence rules.
module tb_store_seq_checker;
    localparam logic [31:0] MA = 32'd80, MD = 32'd7, FA = 32'd84, FD = 32'd7;
    localparam int TO = 90;
    logic clk = 1'b0, reset = 1'b1, memwrite = 1'b0;
    logic [31:0] dataaddr = 32'd0, writedata = 32'd0, pc = 32'd0;
    logic milestone, done, pass, fail;
    logic [2:0] fail_code;
    logic [31:0] fail_pc;
    logic [7:0] store_count;
    logic [15:0] cycle_count;
    int n_cmp = 0, n_bad = 0;
    bit m_ms, m_pass, m_fail;
    int m_code, m_st, m_cy;
    logic [31:0] m_pc;

    store_seq_checker #(
        .MILESTONE_ADDR(MA), .MILESTONE_DATA(MD), .FINAL_ADDR(FA), .FINAL_DATA(FD),
        .TIMEOUT_CYCLES(16'd90)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .pc(pc), .milestone(milestone), .done(done),
        .pass(pass), .fail(fail), .fail_code(fail_code), .fail_pc(fail_pc),
        .store_count(store_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("milestone", milestone, m_ms);
        chk("pass", pass, m_pass);
        chk("fail", fail, m_fail);
        chk("done", done, m_pass | m_fail);
        chk("fail_code", fail_code, m_code);
        chk("fail_pc", fail_pc, m_pc);
        chk("store_count", store_count, m_st);
        chk("cycle_count", cycle_count, m_cy);
    endtask

    // Reference: the run is over once pass or fail is set; otherwise classify the store.
    task automatic model_step(input bit mw, input logic [31:0] a, d, p);
        int code = 0;
        bit moved = 0;
        if (m_pass || m_fail) return;
        if (mw && a == MA) begin
            if (d != MD) code = 1;
            else moved = !m_ms;
        end else if (mw && a == FA) begin
            if (!m_ms) code = 3;
            else if (d != FD) code = 4;
            else moved = 1;
        end else if (mw) code = 2;
        if (code == 0 && !moved && m_cy == TO - 1) code = 5;
        if (m_cy < 65535) m_cy++;
        if (mw && m_st < 255) m_st++;
        if (code != 0) begin
            m_fail = 1; m_code = code; m_pc = p;
        end else if (moved) begin
            if (a == FA) m_pass = 1;
            else m_ms = 1;
        end
    endtask

    task automatic cyc(input bit mw, input logic [31:0] a, d, p);
        memwrite = mw; dataaddr = a; writedata = d; pc = p;
        @(posedge clk);
        model_step(mw, a, d, p);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, $urandom);
    endtask

    // Reset is raised between edges and outputs must clear before any edge arrives.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; memwrite = 1'b0;
        #1;
        m_ms = 0; m_pass = 0; m_fail = 0; m_code = 0; m_pc = 0; m_st = 0; m_cy = 0;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_036();
        do_reset();
        idle(3);
        cyc(1'b1, MA, MD, 32'h0C);
        chk("r036_ms", milestone, 1);
        idle(6);
        cyc(1'b1, FA, FD, 32'h28);
        chk("r036_pass", pass, 1);
        chk("r036_done", done, 1);
        chk("r036_code", fail_code, 0);
        chk("r036_stores", store_count, 2);
        chk("r036_cycles", cycle_count, 11);
    endtask

    initial begin
        run_036();
        cyc(1'b1, FA, 32'd9, 32'h50);
        chk("r030_sticky", pass, 1);
        do_reset();
        cyc(1'b1, MA, 32'd6, 32'h1C);
        chk("r037_fail", fail, 1);
        chk("r037_code", fail_code, 1);
        chk("r037_pc", fail_pc, 32'h1C);
        chk("r037_pass", pass, 0);
        do_reset();
        idle(2);
        cyc(1'b1, 32'd100, MD, 32'h08);
        chk("r038_illegal", fail_code, 2);
        do_reset();
        cyc(1'b1, FA, FD, 32'h04);
        chk("r038_early", fail_code, 3);
        do_reset();
        cyc(1'b1, MA, MD, 32'h10);
        cyc(1'b1, MA, MD, 32'h14);
        cyc(1'b1, FA, 32'd5, 32'h18);
        chk("r039_code", fail_code, 4);
        chk("r039_ms", milestone, 1);
        cyc(1'b1, FA, FD, 32'h1C);
        chk("r039_hold", fail_code, 4);
        chk("r039_nopass", pass, 0);
        chk("r039_stores", store_count, 3);
        do_reset();
        cyc(1'b1, MA, MD, 32'h20);
        idle(89);
        chk("r040_timeout", fail_code, 5);
        chk("r040_cycles", cycle_count, 90);
        do_reset();
        cyc(1'b1, MA, MD, 32'h20);
        idle(88);
        cyc(1'b1, FA, FD, 32'h24);
        chk("r040_pass", pass, 1);
        chk("r040_nofail", fail, 0);
        do_reset();
        idle(2);
        cyc(1'b1, MA, MD, 32'h30);
        idle(2);
        do_reset();
        chk("r041_ms", milestone, 0);
        chk("r041_cycles", cycle_count, 0);
        run_036();
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int c = 0; c < 95; c++) begin
                int sel = $urandom_range(0, 99);
                logic [31:0] a, d;
                a = (sel < 45) ? MA : (sel < 85) ? FA : 32'($urandom_range(0, 63)) << 2;
                d = ($urandom_range(0, 3) != 0) ? 32'd7 : 32'($urandom_range(0, 15));
                cyc($urandom_range(0, 99) < 8, a, d, $urandom);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
